uart_phy: RTL
=============

# uart_phy

Serial line front end for the host UART channel. It sits directly downstream and upstream of the register block. It takes the one-cycle byte strobes that the register block produces on its UART transmit port, buffers them, and shifts them out as 8N1 serial frames. It also deserialises 8N1 frames from the line into a receive FIFO, which the register block reads through a valid/ready handshake.

## Interface
Parameters:
- CLKDIV, default 434: clock cycles per bit. Legal range is 4..65535. The default gives 115200 baud at 50 MHz.
- DEPTH_LOG2, default 4: each FIFO holds 2^DEPTH_LOG2 bytes.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- rstn  in  1  asynchronous, active-low reset.
- tx_valid  in  1  one-cycle strobe; pushes tx_data into the TX FIFO.
- tx_data  in  8  byte to transmit.
- tx_ready  out  1  TX FIFO not full.
- rx_valid  out  1  RX FIFO not empty.
- rx_data  out  8  head byte of the RX FIFO (show-ahead).
- rx_ready  in  1  one-cycle strobe; pops the RX head.
- rxd  in  1  asynchronous serial input; idle high.
- txd  out  1  serial output; idle high.
- rx_ferr  out  1  one-cycle pulse: framing error, byte discarded.
- rx_ovf  out  1  one-cycle pulse: RX FIFO full, byte discarded.
- tx_drop  out  1  one-cycle pulse: tx_valid arrived while the TX FIFO was full, byte discarded.

## Operation
General:
- The upstream writer does not wait for tx_ready. It pulses tx_valid regardless, so a push into a full TX FIFO discards the byte and raises tx_drop. FIFO contents are not changed in that case.
- A pop with rx_valid=0 is ignored. The FIFO pointers do not move.
- Each FIFO uses wrapping pointers with one extra bit to tell full from empty. A simultaneous push and pop on the same FIFO is legal, including when that FIFO is full or empty. When the RX FIFO is empty, the RX push is not visible on rx_data until the following cycle.

TX FSM (IDLE, START, DATA, STOP):
- A bit counter runs 0..CLKDIV-1, and a bit index runs 0..7.
- IDLE: if the TX FIFO is not empty, pop the head into the shift register and go to START.
- START: drive txd=0 for CLKDIV cycles.
- DATA: drive 8 bits LSB first, CLKDIV cycles each.
- STOP: drive txd=1 for CLKDIV cycles, then go to IDLE.
- txd is registered.
- Back-to-back bytes produce no idle gap beyond the single IDLE cycle.

RX path:
- rxd passes through a 2-flop synchroniser.
- RX FSM: IDLE, START, DATA, STOP.
- IDLE: on a synchronised falling edge (1 then 0), load the counter and go to START.
- START: after CLKDIV/2 cycles (integer division), sample the line. If it is 1, treat it as a glitch and return to IDLE. If it is 0, go to DATA.
- DATA: sample every CLKDIV cycles and shift in LSB first, 8 samples.
- STOP: sample after CLKDIV cycles.
  - If the stop sample is 1: push to the RX FIFO, or pulse rx_ovf if the FIFO is full.
  - If the stop sample is 0: pulse rx_ferr and discard the byte.
  - In every case, return to IDLE. A new falling edge is only recognised from IDLE.
- After a framing error, the line must be seen high before the next start is detected (edge detect).

## Timing
Reset values (asserted asynchronously and held while rstn=0):
- txd=1, tx_ready=1, rx_valid=0, rx_data=0.
- rx_ferr, rx_ovf and tx_drop are 0.
- Both FSMs are in IDLE, and both FIFOs and all counters are cleared.

Latencies and sampling:
- Reset mid-frame aborts the frame. txd returns to 1 immediately.
- TX latency: tx_valid at cycle N with an empty FIFO and an idle FSM means the FIFO is non-empty at N+1, the pop happens at N+1, and txd=0 from N+2.
- tx_ready is combinational from the FIFO count. It drops in the cycle after the push that fills the FIFO.
- Frame length is exactly 10*CLKDIV cycles of txd, plus 1 IDLE cycle between frames.
- RX: the 2-flop synchroniser plus the edge register add 3 cycles of delay. Data samples then fall at CLKDIV/2 + k*CLKDIV cycles after the detected edge, for k=1..8, and the stop bit at k=9.
- rx_valid rises 1 cycle after the stop-bit sample.
- rx_data changes only on a pop, or on a push into an empty FIFO.
- Error and drop pulses last exactly 1 cycle and are registered.

## Test plan
Use CLKDIV=8 unless stated.

1. Reset: hold rstn low for 3 cycles, then release -> txd=1, tx_ready=1, rx_valid=0 and all pulses 0. Assert rstn mid-TX frame -> txd=1 in the same cycle.
2. TX single byte: tx_valid with 0x55 -> txd=0 for 8 cycles starting 2 cycles after the strobe, then bits 1,0,1,0,1,0,1,0 (8 cycles each), then 1 for 8 cycles.
3. TX overflow (DEPTH_LOG2=2): 6 back-to-back strobes 0x00..0x05 -> tx_ready low after the FIFO fills. Exactly one tx_drop pulse, for 0x05. Serial output is 0x00..0x04 in order.
4. RX loopback: tie rxd to txd and send 0xA3, then 0x3C -> rx_valid rises after the first frame with rx_data=0xA3. Pulsing rx_ready shows 0x3C once its frame ends. A second pop drops rx_valid to 0.
5. RX errors: drive a frame with stop bit 0 -> rx_ferr pulses once and rx_valid stays 0. Drive a 2-cycle low glitch -> no byte and no pulse. Send 17 frames with DEPTH_LOG2=4 and no pops -> 16 bytes buffered and one rx_ovf pulse.
6. Simultaneous events: pop with rx_ready in the same cycle as a push on a full RX FIFO -> no rx_ovf, count stays 16, and ordering is preserved.

Source files
------------

// File: rtl/uart_phy_if.sv
// Byte-level handshake between the register block and the UART serial front end.
// master = register block side, slave = uart_phy side.
interface uart_phy_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (
    output tx_valid, tx_data, rx_ready,
    input  tx_ready, rx_valid, rx_data
  );

  modport slave (
    input  tx_valid, tx_data, rx_ready,
    output tx_ready, rx_valid, rx_data
  );
endinterface

// File: rtl/uart_phy.sv
// 8N1 UART serial front end: TX FIFO + serialiser, RX synchroniser + deserialiser + RX FIFO.
// A small show-ahead byte FIFO is shared by both directions.
module uart_phy_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? 8'h00 : mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (DEPTH_LOG2+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (DEPTH_LOG2+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
  end
endmodule

module uart_phy #(
  parameter int CLKDIV     = 434,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rstn,
  uart_phy_if.slave   host,
  input  logic        rxd,
  output logic        txd,
  output logic        rx_ferr,
  output logic        rx_ovf,
  output logic        tx_drop
);
  localparam logic [15:0] FULL_M1 = 16'(CLKDIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLKDIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic       tx_pop, tx_full, tx_empty, tx_bit_end, txd_d;
  logic [7:0] tx_head, tx_sh, tx_sh_d;
  logic [15:0] tx_cnt;
  logic [2:0] tx_idx;
  state_t     tx_state, tx_state_d;

  uart_phy_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .rstn(rstn), .push(host.tx_valid), .wdata(host.tx_data),
    .pop(tx_pop), .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  assign host.tx_ready = !tx_full;
  assign tx_bit_end    = (tx_cnt == FULL_M1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tx_state <= S_IDLE;
    else       tx_state <= tx_state_d;
  end

  always_comb begin
    tx_state_d = tx_state;
    case (tx_state)
      S_IDLE:  if (!tx_empty) tx_state_d = S_START;
      S_START: if (tx_bit_end) tx_state_d = S_DATA;
      S_DATA:  if (tx_bit_end && tx_idx == 3'd7) tx_state_d = S_STOP;
      S_STOP:  if (tx_bit_end) tx_state_d = S_IDLE;
      default: tx_state_d = S_IDLE;
    endcase
  end

  // txd is registered from the next state so the line changes with the state.
  always_comb begin
    tx_pop  = (tx_state == S_IDLE) && !tx_empty;
    tx_sh_d = tx_sh;
    if (tx_pop)                                  tx_sh_d = tx_head;
    else if (tx_state == S_DATA && tx_bit_end)   tx_sh_d = {1'b0, tx_sh[7:1]};
    txd_d = 1'b1;
    case (tx_state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = tx_sh_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_cnt  <= '0;
      tx_idx  <= '0;
      txd     <= 1'b1;
      tx_drop <= 1'b0;
    end else begin
      tx_cnt  <= (tx_state == S_IDLE || tx_bit_end) ? '0 : tx_cnt + 16'd1;
      if (tx_state == S_DATA && tx_bit_end) tx_idx <= tx_idx + 3'd1;
      txd     <= txd_d;
      tx_drop <= host.tx_valid && tx_full && !tx_pop;
    end
  end

  always_ff @(posedge clk) tx_sh <= tx_sh_d;

  logic       rxd_p0, rxd_p1, rxd_p2;
  logic       rx_fall, rx_half_end, rx_bit_end, rx_push, rx_ferr_d;
  logic       rx_full, rx_empty;
  logic [7:0] rx_sh, rx_head;
  logic [15:0] rx_cnt;
  logic [2:0] rx_idx;
  state_t     rx_state, rx_state_d;

  // p0/p1: metastability synchroniser; p2: edge-detect history
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
      rxd_p2 <= 1'b1;
    end else begin
      rxd_p0 <= rxd;
      rxd_p1 <= rxd_p0;
      rxd_p2 <= rxd_p1;
    end
  end

  assign rx_fall     = rxd_p2 && !rxd_p1;
  assign rx_half_end = (rx_cnt == HALF_M1);
  assign rx_bit_end  = (rx_cnt == FULL_M1);

  uart_phy_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .rstn(rstn), .push(rx_push), .wdata(rx_sh),
    .pop(host.rx_ready), .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );

  assign host.rx_valid = !rx_empty;
  assign host.rx_data  = rx_head;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rx_state <= S_IDLE;
    else       rx_state <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state;
    case (rx_state)
      S_IDLE:  if (rx_fall) rx_state_d = S_START;
      S_START: if (rx_half_end) rx_state_d = rxd_p1 ? S_IDLE : S_DATA;
      S_DATA:  if (rx_bit_end && rx_idx == 3'd7) rx_state_d = S_STOP;
      S_STOP:  if (rx_bit_end) rx_state_d = S_IDLE;
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_push   = (rx_state == S_STOP) && rx_bit_end && rxd_p1;
    rx_ferr_d = (rx_state == S_STOP) && rx_bit_end && !rxd_p1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_cnt  <= '0;
      rx_idx  <= '0;
      rx_ferr <= 1'b0;
      rx_ovf  <= 1'b0;
    end else begin
      if (rx_state == S_IDLE || (rx_state == S_START && rx_half_end) ||
          (rx_state != S_START && rx_bit_end))
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 16'd1;
      if (rx_state == S_DATA && rx_bit_end) rx_idx <= rx_idx + 3'd1;
      rx_ferr <= rx_ferr_d;
      rx_ovf  <= rx_push && rx_full && !host.rx_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_state == S_DATA && rx_bit_end) rx_sh <= {rxd_p1, rx_sh[7:1]};
  end
endmodule
